// File: rtl/reset_sequencer.sv
// reset_sequencer: debounces the front-panel button and releases video then CPU resets
// in a staggered, registered sequence that a debounced press re-runs.
module reset_sequencer #(
  parameter int CNT_W          = 16,
  parameter int DEB_COUNT      = 12000,
  parameter int HOLD_CYCLES    = 256,
  parameter int STAGGER_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic button_db,
  output logic button_pulse,
  output logic video_reset,
  output logic cpu_reset,
  output logic ready
);
  typedef enum logic [1:0] {ST_HOLD, ST_VIDEO, ST_RUN} state_t;
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_COUNT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  logic             bs1_q, bs2_q;
  logic             button_db_q, button_db_d;
  logic             button_pulse_q, button_pulse_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
  state_t           state_q, state_d;
  logic             video_reset_q, cpu_reset_q, ready_q;
  always_comb begin
    button_db_d = button_db_q;
    deb_cnt_d   = '0;
    if (bs2_q != button_db_q) begin
      if (deb_cnt_q == DEB_LAST) button_db_d = bs2_q;
      else deb_cnt_d = deb_cnt_q + ONE;
    end
    button_pulse_d = button_db_d & ~button_db_q;
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (button_db_q) seq_cnt_d = '0;
        else if (seq_cnt_q == HOLD_LAST) begin
          seq_cnt_d = '0;
          state_d   = ST_VIDEO;
        end else seq_cnt_d = seq_cnt_q + ONE;
      end
      ST_VIDEO: begin
        if (button_pulse_q) begin
          seq_cnt_d = '0;
          state_d   = ST_HOLD;
        end else if (seq_cnt_q == STAG_LAST) begin
          seq_cnt_d = '0;
          state_d   = ST_RUN;
        end else seq_cnt_d = seq_cnt_q + ONE;
      end
      ST_RUN: begin
        if (button_pulse_q) begin
          seq_cnt_d = '0;
          state_d   = ST_HOLD;
        end
      end
      default: begin
        seq_cnt_d = '0;
        state_d   = ST_HOLD;
      end
    endcase
  end
  // Reset outputs are decoded from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      bs1_q          <= 1'b0;
      bs2_q          <= 1'b0;
      button_db_q    <= 1'b0;
      button_pulse_q <= 1'b0;
      deb_cnt_q      <= '0;
      state_q        <= ST_HOLD;
      seq_cnt_q      <= '0;
      video_reset_q  <= 1'b1;
      cpu_reset_q    <= 1'b1;
      ready_q        <= 1'b0;
    end else begin
      bs1_q          <= button;
      bs2_q          <= bs1_q;
      button_db_q    <= button_db_d;
      button_pulse_q <= button_pulse_d;
      deb_cnt_q      <= deb_cnt_d;
      state_q        <= state_d;
      seq_cnt_q      <= seq_cnt_d;
      video_reset_q  <= state_d == ST_HOLD;
      cpu_reset_q    <= state_d != ST_RUN;
      ready_q        <= state_d == ST_RUN;
    end
  end
  assign button_db    = button_db_q;
  assign button_pulse = button_pulse_q;
  assign video_reset  = video_reset_q;
  assign cpu_reset    = cpu_reset_q;
  assign ready        = ready_q;
endmodule
